// File: rtl/icache.sv
// Direct-mapped instruction cache: serves 32-bit words to fetch on a hit and
// refills one aligned block from the memory controller on a miss.
module icache #(
    parameter int BLOCK_WIDTH = 1,
    parameter int BLOCK_SIZE  = 1 << BLOCK_WIDTH,
    parameter int CACHE_SIZE  = 8,
    parameter int BLOCK_NUM   = 1 << CACHE_SIZE,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       IF2IC_en,
    input  logic [ADDR_WIDTH-1:0]      IF2IC_addr,
    input  logic                       IF2IC_clear,
    output logic                       IC2IF_en,
    output logic [31:0]                IC2IF_inst,
    output logic                       IC2MC_en,
    output logic [ADDR_WIDTH-1:0]      IC2MC_addr,
    input  logic                       MC2IC_en,
    input  logic [32*BLOCK_SIZE-1:0]   MC2IC_block
);

    localparam int OFFSET_BITS = BLOCK_WIDTH + 2;
    localparam int TAG_LSB     = BLOCK_WIDTH + CACHE_SIZE + 2;
    localparam int TAG_WIDTH   = ADDR_WIDTH - TAG_LSB;

    typedef enum logic {IDLE, MISS} state_t;
    typedef logic [BLOCK_SIZE-1:0][31:0] line_t;

    state_t                   state_q, state_d;
    logic                     drop_q, drop_d;
    logic                     if_en_q, if_en_d;
    logic [31:0]              if_inst_q, if_inst_d;
    logic                     mc_en_q, mc_en_d;
    logic [ADDR_WIDTH-1:0]    mc_addr_q, mc_addr_d;
    logic [BLOCK_WIDTH-1:0]   miss_word_q, miss_word_d;

    logic [BLOCK_NUM-1:0]     valid_q;
    logic [TAG_WIDTH-1:0]     tag_mem  [BLOCK_NUM];
    line_t                    data_mem [BLOCK_NUM];

    logic [CACHE_SIZE-1:0]    req_index;
    logic [TAG_WIDTH-1:0]     req_tag;
    logic [BLOCK_WIDTH-1:0]   req_word;
    logic                     req_hit;
    logic [CACHE_SIZE-1:0]    fill_index;
    logic [TAG_WIDTH-1:0]     fill_tag;
    logic                     fill_we;
    line_t                    mc_words;
    logic                     unused_addr_bits;

    assign req_index  = IF2IC_addr[TAG_LSB-1:OFFSET_BITS];
    assign req_tag    = IF2IC_addr[ADDR_WIDTH-1:TAG_LSB];
    assign req_word   = IF2IC_addr[OFFSET_BITS-1:2];
    assign req_hit    = valid_q[req_index] && (tag_mem[req_index] == req_tag);

    // The outstanding block address doubles as the fill index/tag source.
    assign fill_index = mc_addr_q[TAG_LSB-1:OFFSET_BITS];
    assign fill_tag   = mc_addr_q[ADDR_WIDTH-1:TAG_LSB];
    assign mc_words   = MC2IC_block;

    assign unused_addr_bits = ^IF2IC_addr[1:0];

    assign IC2IF_en   = if_en_q;
    assign IC2IF_inst = if_inst_q;
    assign IC2MC_en   = mc_en_q;
    assign IC2MC_addr = mc_addr_q;

    always_comb begin
        // NOTE: every signal gets a default here so no path can infer a latch.
        state_d     = state_q;
        drop_d      = drop_q;
        if_en_d     = 1'b0;
        if_inst_d   = if_inst_q;
        mc_en_d     = mc_en_q;
        mc_addr_d   = mc_addr_q;
        miss_word_d = miss_word_q;
        fill_we     = 1'b0;

        unique case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                // A strobe in the previous cycle blocks service so the
                // response never stays high for two cycles in a row.
                if (IF2IC_en && !IF2IC_clear && !if_en_q) begin
                    if (req_hit) begin
                        if_en_d   = 1'b1;
                        if_inst_d = data_mem[req_index][req_word];
                    end else begin
                        mc_addr_d   = {IF2IC_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                        mc_en_d     = 1'b1;
                        miss_word_d = req_word;
                        state_d     = MISS;
                    end
                end
            end
            MISS: begin
                if (IF2IC_clear) begin
                    drop_d = 1'b1;
                end
                if (MC2IC_en) begin
                    fill_we = 1'b1;
                    mc_en_d = 1'b0;
                    drop_d  = 1'b0;
                    state_d = IDLE;
                    if (!drop_q && !IF2IC_clear) begin
                        if_en_d   = 1'b1;
                        if_inst_d = mc_words[miss_word_q];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            drop_q      <= 1'b0;
            if_en_q     <= 1'b0;
            if_inst_q   <= '0;
            mc_en_q     <= 1'b0;
            mc_addr_q   <= '0;
            miss_word_q <= '0;
            valid_q     <= '0;
        end else if (rdy_in) begin
            // NOTE: non-blocking updates keep all registers sampling pre-edge values.
            state_q     <= state_d;
            drop_q      <= drop_d;
            if_en_q     <= if_en_d;
            if_inst_q   <= if_inst_d;
            mc_en_q     <= mc_en_d;
            mc_addr_q   <= mc_addr_d;
            miss_word_q <= miss_word_d;
            if (fill_we) begin
                valid_q[fill_index] <= 1'b1;
            end
        end
    end

    // NOTE: tag and data arrays are not reset; the valid bits alone gate their use.
    always_ff @(posedge clk_in) begin
        if (rdy_in && fill_we) begin
            tag_mem[fill_index]  <= fill_tag;
            data_mem[fill_index] <= mc_words;
        end
    end

endmodule
